// File: rtl/uart_frame_tx_if.sv
// Frame handshake between the screen FIFO output port and the serial transmitter.
// Handshake: a frame moves on a rising clk edge where ivalid && iready are both 1;
// the master holds idata stable while ivalid is high, and the slave never
// samples idata on any other edge.
interface uart_frame_tx_if;
    logic       ivalid;
    logic       iready;
    logic [9:0] idata;

    modport master (output ivalid, output idata, input iready);
    modport slave  (input ivalid, input idata, output iready);
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame serializer: takes one 10-bit pre-framed word per handshake and
// shifts it out LSB-first, each bit held CLKS_PER_BIT clocks, with an optional
// idle gap of GAP_BITS bit periods after every frame. All outputs are registered.
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 0
) (
    input  logic             clk,
    input  logic             reset_n,   // active-high asynchronous reset
    uart_frame_tx_if.slave   in_if,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       state_dbg
);
    localparam int BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_TOTAL = GAP_BITS * CLKS_PER_BIT;
    localparam int GW        = (GAP_TOTAL > 1) ? $clog2(GAP_TOTAL) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TOTAL > 0) ? (GAP_TOTAL - 1) : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

    state_t        state, state_nx;
    logic [9:0]    shreg, shreg_nx;
    logic [3:0]    bit_idx, bit_idx_nx;
    logic [BW-1:0] baud_cnt, baud_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          ready_q, ready_nx;
    logic          tx_nx, busy_nx, done_nx, err_nx;
    logic          accept, baud_end, last_bit, gap_end;

    // Only the IDLE state with a registered ready can take a frame.
    assign accept   = (state == IDLE) && in_if.ivalid && ready_q;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign last_bit = (bit_idx == 4'd9);
    assign gap_end  = (gap_cnt == GAP_LAST);

    assign in_if.iready = ready_q;
    assign state_dbg    = state;

    // State register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decision: accept -> shift ten bits -> optional gap -> idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (baud_end && last_bit) state_nx = (GAP_BITS == 0) ? IDLE : GAP;
            GAP:     if (gap_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        baud_nx    = baud_cnt;
        gap_nx     = gap_cnt;
        tx_nx      = tx;
        ready_nx   = ready_q;
        busy_nx    = busy;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
                if (accept) begin
                    shreg_nx   = in_if.idata;
                    tx_nx      = in_if.idata[0];
                    bit_idx_nx = 4'd0;
                    baud_nx    = '0;
                    ready_nx   = 1'b0;
                    busy_nx    = 1'b1;
                    err_nx     = in_if.idata[0] | ~in_if.idata[9];
                end
            end
            SHIFT: begin
                if (baud_end) begin
                    baud_nx = '0;
                    if (last_bit) begin
                        // Stop bit finished; the line goes high for at least one clock.
                        done_nx = 1'b1;
                        tx_nx   = 1'b1;
                        gap_nx  = '0;
                        if (GAP_BITS == 0) begin
                            ready_nx = 1'b1;
                            busy_nx  = 1'b0;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                        shreg_nx   = {1'b1, shreg[9:1]};
                        tx_nx      = shreg[1];
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            GAP: begin
                tx_nx = 1'b1;
                if (gap_end) begin
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            default: begin
                tx_nx = 1'b1;
            end
        endcase
    end

    // Datapath and output registers; reset forces the line high and drops ready.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            shreg      <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
            gap_cnt    <= '0;
            tx         <= 1'b1;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            shreg      <= shreg_nx;
            bit_idx    <= bit_idx_nx;
            baud_cnt   <= baud_nx;
            gap_cnt    <= gap_nx;
            tx         <= tx_nx;
            ready_q    <= ready_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: two instances (no gap / two-bit gap) at 4 clocks per bit,
// driven through a shared stream driver and checked against a line-level model.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic ivalid;
    logic [9:0] idata;
    int sel;
    int unsigned cyc = 0;

    int tests_run = 0;
    int tests_failed = 0;

    logic tx0, busy0, done0, err0, tx2, busy2, done2, err2;
    logic [1:0] st0, st2;
    logic tx_m, busy_m, done_m, err_m, iready_m;

    uart_frame_tx_if if0 ();
    uart_frame_tx_if if2 ();

    assign if0.ivalid = ivalid && (sel == 0);
    assign if2.ivalid = ivalid && (sel == 1);
    assign if0.idata  = idata;
    assign if2.idata  = idata;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_if(if0.slave),
        .tx(tx0), .busy(busy0), .frame_done(done0), .frame_err(err0), .state_dbg(st0)
    );
    uart_frame_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_if(if2.slave),
        .tx(tx2), .busy(busy2), .frame_done(done2), .frame_err(err2), .state_dbg(st2)
    );

    assign tx_m     = (sel == 1) ? tx2 : tx0;
    assign busy_m   = (sel == 1) ? busy2 : busy0;
    assign done_m   = (sel == 1) ? done2 : done0;
    assign err_m    = (sel == 1) ? err2 : err0;
    assign iready_m = (sel == 1) ? if2.iready : if0.iready;

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stream driver state and observations
    logic [9:0] frame_q[$];
    logic obs_tx[$], obs_done[$], obs_err[$], obs_rdy[$], obs_busy[$];
    int unsigned acc_cyc[$];
    int P;
    bit timed_out;

    // Sends frame_q with ivalid held high, one sample per cycle after the first accept.
    task automatic drive_stream(input int n);
        int next;
        int guard;
        bit just_acc;
        obs_tx.delete(); obs_done.delete(); obs_err.delete(); obs_rdy.delete(); obs_busy.delete();
        acc_cyc.delete();
        timed_out = 0;
        P = 10 * CPB + 1 + ((sel == 1) ? 2 : 0) * CPB;
        @(negedge clk);
        idata = frame_q[0];
        ivalid = 1'b1;
        guard = 0;
        while (iready_m !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            timed_out = 1;
            ivalid = 1'b0;
            return;
        end
        acc_cyc.push_back(cyc);
        just_acc = 1;
        next = 1;
        for (int s = 0; s < n * P; s++) begin
            @(negedge clk);
            obs_tx.push_back(tx_m);
            obs_done.push_back(done_m);
            obs_err.push_back(err_m);
            obs_rdy.push_back(iready_m);
            obs_busy.push_back(busy_m);
            if (just_acc) begin
                just_acc = 0;
                if (next < n) begin
                    idata = frame_q[next];
                    next++;
                end else begin
                    ivalid = 1'b0;
                    idata = 10'($urandom_range(0, 1023));
                end
            end else if (ivalid && iready_m === 1'b1) begin
                acc_cyc.push_back(cyc);
                just_acc = 1;
            end
        end
        ivalid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        ivalid = 1'b0;
        idata = '0;
        sel = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx0, busy0, if0.iready, done0, err0} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_dut0 got %b exp 10000", {tx0, busy0, if0.iready, done0, err0});
        end
        tests_run++;
        if ({tx2, busy2, if2.iready, done2, err2} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_dut2 got %b exp 10000", {tx2, busy2, if2.iready, done2, err2});
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (if0.iready !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_no_edge_iready got %b exp 0", if0.iready);
        end
        @(negedge clk);
        tests_run++;
        if ({tx0, busy0, if0.iready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL first_edge got %b exp 101", {tx0, busy0, if0.iready});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if ({tx0, busy0, if0.iready, done0, err0} !== 5'b10100) begin
                tests_failed++;
                $display("FAIL idle[%0d] got %b exp 10100", k, {tx0, busy0, if0.iready, done0, err0});
            end
        end
    endtask

    // One frame per call, each compared sample-by-sample with the line model.
    task automatic test_single();
        logic [9:0] tbl[5];
        int i, o;
        logic e_tx, e_done, e_rdy, e_err;
        sel = 0;
        tbl[0] = 10'h2AA;
        tbl[1] = 10'h155;
        tbl[2] = 10'($urandom_range(0, 1023));
        tbl[3] = {1'b1, 8'($urandom_range(0, 255)), 1'b0};
        tbl[4] = 10'($urandom_range(0, 1023));
        for (int t = 0; t < 5; t++) begin
            frame_q.delete();
            frame_q.push_back(tbl[t]);
            drive_stream(1);
            tests_run++;
            if (timed_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL single[%0d] accept_timeout got 1 exp 0", t);
                continue;
            end
            for (int s = 0; s < P; s++) begin
                i = s / P;
                o = s % P;
                e_tx   = (o < 10 * CPB) ? frame_q[i][o / CPB] : 1'b1;
                e_done = (o == 10 * CPB);
                e_rdy  = (o == P - 1);
                e_err  = (o == 0) && (frame_q[i][0] !== 1'b0 || frame_q[i][9] !== 1'b1);
                tests_run++;
                if ({obs_tx[s], obs_done[s], obs_rdy[s], obs_busy[s], obs_err[s]} !== {e_tx, e_done, e_rdy, !e_rdy, e_err}) begin
                    tests_failed++;
                    $display("FAIL single[%0d] frame=%h s=%0d tx/done/rdy/busy/err got %b exp %b", t, tbl[t], s,
                             {obs_tx[s], obs_done[s], obs_rdy[s], obs_busy[s], obs_err[s]},
                             {e_tx, e_done, e_rdy, !e_rdy, e_err});
                end
            end
        end
    endtask

    // Streams with ivalid held high: accept spacing and the whole line waveform.
    task automatic test_back_to_back();
        int i, o, n;
        logic e_tx, e_done, e_rdy, e_err;
        for (int t = 0; t < 3; t++) begin
            frame_q.delete();
            if (t == 0) begin
                sel = 0;
                frame_q.push_back(10'h200);
                frame_q.push_back(10'h3FE);
            end else if (t == 1) begin
                sel = 0;
                for (int k = 0; k < 3; k++) frame_q.push_back({1'b1, 8'($urandom_range(0, 255)), 1'b0});
            end else begin
                sel = 1;
                for (int k = 0; k < 2; k++) frame_q.push_back(10'($urandom_range(0, 1023)));
            end
            n = frame_q.size();
            drive_stream(n);
            tests_run++;
            if (timed_out !== 1'b0 || acc_cyc.size() != n) begin
                tests_failed++;
                $display("FAIL b2b[%0d] accepts got %0d exp %0d", t, acc_cyc.size(), n);
                continue;
            end
            for (int k = 1; k < n; k++) begin
                tests_run++;
                if (acc_cyc[k] - acc_cyc[k-1] != P) begin
                    tests_failed++;
                    $display("FAIL b2b[%0d] accept_period got %0d exp %0d", t, acc_cyc[k] - acc_cyc[k-1], P);
                end
            end
            for (int s = 0; s < n * P; s++) begin
                i = s / P;
                o = s % P;
                e_tx   = (o < 10 * CPB) ? frame_q[i][o / CPB] : 1'b1;
                e_done = (o == 10 * CPB);
                e_rdy  = (o == P - 1);
                e_err  = (o == 0) && (frame_q[i][0] !== 1'b0 || frame_q[i][9] !== 1'b1);
                tests_run++;
                if ({obs_tx[s], obs_done[s], obs_rdy[s], obs_busy[s], obs_err[s]} !== {e_tx, e_done, e_rdy, !e_rdy, e_err}) begin
                    tests_failed++;
                    $display("FAIL b2b[%0d] s=%0d tx/done/rdy/busy/err got %b exp %b", t, s,
                             {obs_tx[s], obs_done[s], obs_rdy[s], obs_busy[s], obs_err[s]},
                             {e_tx, e_done, e_rdy, !e_rdy, e_err});
                end
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        bit seen_done;
        logic [9:0] f;
        sel = 0;
        @(negedge clk);
        idata = 10'h200;
        ivalid = 1'b1;
        guard = 0;
        while (if0.iready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        ivalid = 1'b0;
        repeat (21) @(negedge clk);
        tests_run++;
        if (tx0 !== 1'b0 || guard >= 200) begin
            tests_failed++;
            $display("FAIL midreset_bit5_low got %b exp 0", tx0);
        end
        reset_n = 1'b1;
        #1;
        tests_run++;
        if ({tx0, if0.iready, busy0} !== 3'b100) begin
            tests_failed++;
            $display("FAIL midreset_async got %b exp 100", {tx0, if0.iready, busy0});
        end
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done0 !== 1'b0) seen_done = 1;
        end
        reset_n = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done0 !== 1'b0 || tx0 !== 1'b1) seen_done = 1;
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_done got %b exp 0", seen_done);
        end
        f = {1'b1, 8'($urandom_range(0, 255)) | 8'h01, 1'b0};
        frame_q.delete();
        frame_q.push_back(f);
        drive_stream(1);
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_restart_timeout got 1 exp 0");
        end else begin
            for (int s = 0; s < CPB; s++) begin
                tests_run++;
                if (obs_tx[s] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL midreset_bit0[%0d] got %b exp 0", s, obs_tx[s]);
                end
            end
            tests_run++;
            if (obs_tx[CPB] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midreset_bit1 got %b exp 1", obs_tx[CPB]);
            end
            tests_run++;
            if (obs_done[10 * CPB] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midreset_done got %b exp 1", obs_done[10 * CPB]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serial transmitter at the consumer end of the screen data FIFO. It accepts one 10-bit UART-formatted frame per ready/valid handshake and shifts it out LSB-first on a single line to the display. Each bit is held for a parameterised number of clock cycles. It sits between the FIFO output port (`ovalid`/`odata`/`oready`) and the screen's serial input pin.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.
- `GAP_BITS`, default 0: idle (`tx`=1) bit periods inserted after each frame's last bit; 0 means no gap.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-high: 1 = reset asserted, 0 = run.
- `ivalid`  in  1  frame on `idata` is valid; driven from FIFO `ovalid`.
- `iready`  out  1  block can accept a frame this cycle; drives FIFO `oready`.
- `idata`  in  10  frame: bit0 = start (0), bits[8:1] = data LSB-first, bit9 = stop (1).
- `tx`  out  1  serial line to screen; idles high.
- `busy`  out  1  1 while a frame or gap is being sent.
- `frame_done`  out  1  single-cycle pulse when a frame's bit9 period completes.
- `frame_err`  out  1  single-cycle pulse at accept if `idata[0]`≠0 or `idata[9]`≠1.

## Operation
- FSM states: IDLE, SHIFT, GAP. All outputs are registered.
- Reset (async, while `reset_n`=1): state=IDLE, `tx`=1, `iready`=0, `busy`=0, `frame_done`=0, `frame_err`=0, counters=0.
- At the first edge after reset release, `iready` goes to 1.
- IDLE:
  - `iready`=1, `tx`=1.
  - Accept occurs on the edge where `ivalid`&&`iready`. At that edge: shift register←`idata`, `tx`←`idata[0]`, bit index←0, baud counter←0, `iready`←0, `busy`←1, state←SHIFT.
  - `frame_err`←malformed check on the same edge.
- SHIFT:
  - The baud counter counts 0..`CLKS_PER_BIT`-1.
  - At terminal count with bit index<9: bit index+1, `tx`←next bit, counter←0.
  - At terminal count with bit index=9: `frame_done`←1 for one cycle. If `GAP_BITS`=0: state←IDLE, `iready`←1, `busy`←0. Otherwise state←GAP.
  - `tx`←1 in both cases.
- GAP: `tx`=1 for `GAP_BITS`×`CLKS_PER_BIT` cycles, then state←IDLE, `iready`←1, `busy`←0.
- Malformed frames are still transmitted exactly as given; `frame_err` is only a flag.
- `idata` and `ivalid` are ignored outside the accept edge. A change in `idata` mid-frame has no effect.
- `ivalid` may be held high continuously; exactly one frame is consumed per `iready`=1 cycle in which `ivalid`=1.
- Width rules:
  - Baud counter is $clog2(`CLKS_PER_BIT`) bits, gap counter is sized for `GAP_BITS`×`CLKS_PER_BIT`, bit index is 4 bits.
  - No counter wraps except by explicit clear.

## Timing
- Accept edge to first `tx` transition (bit0): 0 cycles; `tx` updates on the accept edge itself.
- Each bit is held exactly `CLKS_PER_BIT` cycles; frame on the line = 10×`CLKS_PER_BIT` cycles.
- `frame_done` is asserted in the cycle after bit9's final cycle, i.e. the cycle in which `iready` returns to 1 (when `GAP_BITS`=0).
- Back-to-back throughput with `ivalid` held high: accept period = 10×`CLKS_PER_BIT` + 1 + `GAP_BITS`×`CLKS_PER_BIT` cycles. The extra cycle is one clock of `tx`=1 that extends the stop bit.
- Reset mid-frame: `tx`=1 and `iready`=0 immediately (asynchronous). The frame is abandoned, with no `frame_done` and no FIFO pop, since `iready` was low.

## Test plan
- Reset then idle, no `ivalid`: `tx`=1, `busy`=0, `iready`=0 during reset and 1 from the first edge after release; no pulses.
- `CLKS_PER_BIT`=4, `idata`=10'h2AA (byte 0x55), one `ivalid` pulse: `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `frame_done` fires 40 cycles after accept, `frame_err`=0, `iready` returns to 1 at that same cycle.
- `CLKS_PER_BIT`=4, `ivalid` held high with frames 10'h200 then 10'h3FE: two accepts exactly 41 cycles apart. Line shows 0×9 then 1, one extra high cycle, then 0 followed by 1×9.
- `idata`=10'h155 (start=1, stop=0): `frame_err` pulses on the accept edge, the frame is still serialised bit-exact, and `frame_done` still fires.
- `GAP_BITS`=2, `CLKS_PER_BIT`=4, two frames back-to-back: accepts 49 cycles apart, `tx`=1 and `busy`=1 for 8 cycles after `frame_done`.
- Assert `reset_n` at bit 5 of a frame: `tx`→1 asynchronously, no `frame_done`. After release, the next `ivalid` starts a fresh frame with bit0 held a full 4 cycles.
